// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder stage reused for WIDTH cycles, with a start/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bit_s, bit_c, last_bit, accept;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // The single shared full-adder stage and handshake qualifiers
    always_comb begin
        bit_s    = sh_a_q[0] ^ sh_b_q[0] ^ carry_q;
        bit_c    = (sh_a_q[0] & sh_b_q[0]) | (sh_a_q[0] & carry_q) | (sh_b_q[0] & carry_q);
        last_bit = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
        accept   = start && ((state_q == IDLE) || (state_q == FIN));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_bit) state_d = FIN;
            FIN:     state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == FIN);
        sum  = sum_q;
        cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf  = ovf_q;
`endif
    end

    // FIN accepts a new start just like IDLE, so back-to-back sums are WIDTH+1 cycles apart
    always_comb begin
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (accept) begin
            sh_a_d  = a;
            sh_b_d  = b;
            carry_d = cin;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            sh_a_d  = {1'b0, sh_a_q[WIDTH-1:1]};
            sh_b_d  = {1'b0, sh_b_q[WIDTH-1:1]};
            acc_d   = {bit_s, acc_q[WIDTH-1:1]};
            carry_d = bit_c;
            cnt_d   = cnt_q + CW'(1);
            if (last_bit) begin
                sum_d  = {bit_s, acc_q[WIDTH-1:1]};
                cout_d = bit_c;
`ifdef SERIAL_ADDER_OVF_EN
                // carry_q here is the carry into the MSB
                ovf_d  = carry_q ^ bit_c;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder that time-multiplexes one full-adder stage (sum = a^b^c, carry = majority(a,b,c)) across WIDTH cycles.
- A registered carry feeds back between bits.
- Feeds the single-stage adder with one operand bit pair per cycle and consumes its carry. Trades area for latency in the logic-simulator examples.
- Start/done handshake so a testbench or controller can sequence multiple additions.

Parameters:
- WIDTH, 8, operand and sum width in bits (>=2)
- CW, $clog2(WIDTH+1), bit-counter width (derived, not overridden)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request: begin addition of a, b, cin
- a  in  WIDTH  operand A, sampled only when start is accepted
- b  in  WIDTH  operand B, sampled only when start is accepted
- cin  in  1  carry-in, sampled with a/b
- busy  out  1  high while bits are being processed
- done  out  1  one-cycle pulse, result valid
- sum  out  WIDTH  registered result
- cout  out  1  registered carry-out of MSB

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, sum=0, cout=0; internal shift regs, carry, and counter cleared. Outputs go low immediately, not at the next edge.
- FSM states: IDLE, RUN, FIN.
- IDLE: start=1 at edge E0 -> load shA=a, shB=b, carry=cin, cnt=0, and an internal accumulator acc=0; go to RUN; busy=1 after E0.
- RUN, each edge:
  - s = shA[0]^shB[0]^carry; carry <= majority(shA[0], shB[0], carry).
  - acc <= {s, acc[WIDTH-1:1]}; shA, shB shift right by 1 (zero fill); cnt <= cnt+1.
  - When cnt==WIDTH-1 this edge: sum <= final acc value including s; cout <= new carry; go to FIN; busy<=0; done<=1.
- Latency: done high in the cycle after edge E0+WIDTH, i.e. WIDTH cycles after start accepted.
- FIN: lasts exactly one cycle (done=1), then -> IDLE, done<=0. start=1 in FIN is accepted exactly as in IDLE: reload, go to RUN, busy=1, done=0 next cycle. Back-to-back additions are therefore WIDTH+1 cycles apart.
- start while in RUN: ignored; operands not resampled; no effect on the result.
- sum/cout hold the previous result throughout RUN and change only on the completing edge. They hold indefinitely until the next completion or reset.
- Arithmetic: {cout,sum} = a + b + cin modulo 2^(WIDTH+1), unsigned.
- Wrap-around example: a=all ones, b=0, cin=1 -> sum=0, cout=1.
- rst asserted mid-RUN: abort immediately to reset values; no done pulse; the partial result is discarded.
- Input changes on a/b/cin outside the accept edge: no effect.

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- Defined: extra output port ovf (out, 1) = signed two's-complement overflow = carry into the MSB XOR carry out of the MSB. Registered and updated with sum/cout; reset 0.
- Not defined: port absent; no extra logic.

Test Plan:
- Reset check: rst pulse mid-cycle, no clock edge -> busy=0, done=0, sum=0x00, cout=0 immediately.
- Basic, WIDTH=8: start with a=0x35, b=0x4A, cin=0 -> busy=1 for 8 cycles, done pulse 1 cycle, sum=0x7F, cout=0.
- Carry chain: a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1. Also a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Handshake: start held high across RUN with different a/b -> result from first-sampled operands only. Start in the FIN cycle -> second addition begins; done pulses exactly 9 cycles apart.
- Reset mid-operation: rst at cycle 4 of RUN for a=0x10, b=0x10 -> no done pulse, sum stays 0. A subsequent start with a=0x01, b=0x02 -> sum=0x03.
- With SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1. Also a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
